ristretto_pipe_ctrl_unit: RTL and testbench

Central Pipeline Control Unit for the ristretto 32-bit in-order core. It collects hazard, busy and redirect requests from the decode, execute and memory stages. From these it drives the stall/flush inputs of every pipeline register (IF, IF/DEC, DEC/EX, EX/MEM) and the PC-reload request to fetch. A small FSM sequences multi-cycle flushes after control-flow changes and long memory waits.

---
 rtl/ristretto_pipe_ctrl_unit_if.sv | 43 ++++
 rtl/ristretto_pipe_ctrl_unit.sv | 133 +++++++++++++
 tb/tb_ristretto_pipe_ctrl_unit.sv | 192 +++++++++++++++++++
 3 files changed

// File: rtl/ristretto_pipe_ctrl_unit_if.sv
// Purpose: bundles the hazard/redirect requests and stall/flush/PC-reload controls of the ristretto pipeline control unit.
// Latency: none, pure wiring.
// Backpressure: redirect/trap requests are held by their sources until accepted (pc_load strobe).
// Ports: slave = control unit side (requests in, controls out); master = pipeline stage side.
interface ristretto_pipe_ctrl_unit_if #(
    parameter int DataWidth = 32
);
    logic                 pcu_load_use_i;
    logic                 pcu_md_busy_i;
    logic                 pcu_mem_busy_i;
    logic                 pcu_redirect_i;
    logic [DataWidth-1:0] pcu_redirect_pc_i;
    logic                 pcu_trap_i;
    logic [DataWidth-1:0] pcu_trap_vec_i;
    logic                 pcu_if_stall_o;
    logic                 pcu_if_dec_stall_o;
    logic                 pcu_if_dec_flush_o;
    logic                 pcu_dec_ex_stall_o;
    logic                 pcu_dec_ex_flush_o;
    logic                 pcu_ex_mem_stall_o;
    logic                 pcu_ex_mem_flush_o;
    logic                 pcu_pc_load_o;
    logic [DataWidth-1:0] pcu_pc_o;
    logic [1:0]           pcu_state_o;

    modport slave (
        input  pcu_load_use_i, pcu_md_busy_i, pcu_mem_busy_i,
        input  pcu_redirect_i, pcu_redirect_pc_i, pcu_trap_i, pcu_trap_vec_i,
        output pcu_if_stall_o, pcu_if_dec_stall_o, pcu_if_dec_flush_o,
        output pcu_dec_ex_stall_o, pcu_dec_ex_flush_o,
        output pcu_ex_mem_stall_o, pcu_ex_mem_flush_o,
        output pcu_pc_load_o, pcu_pc_o, pcu_state_o
    );

    modport master (
        output pcu_load_use_i, pcu_md_busy_i, pcu_mem_busy_i,
        output pcu_redirect_i, pcu_redirect_pc_i, pcu_trap_i, pcu_trap_vec_i,
        input  pcu_if_stall_o, pcu_if_dec_stall_o, pcu_if_dec_flush_o,
        input  pcu_dec_ex_stall_o, pcu_dec_ex_flush_o,
        input  pcu_ex_mem_stall_o, pcu_ex_mem_flush_o,
        input  pcu_pc_load_o, pcu_pc_o, pcu_state_o
    );
endinterface

// File: rtl/ristretto_pipe_ctrl_unit.sv
// Purpose: central pipeline control; turns hazard/busy/redirect/trap requests into per-register stall/flush and PC reload.
// Latency: zero cycles, controls are combinational from state, flush counter and current requests.
// Backpressure: redirect/trap are not accepted while mem_busy is high; their sources must hold them.
// Ports: clk_i, rstn_i (async active-low), pcu (slave modport of ristretto_pipe_ctrl_unit_if),
//        pcu_wdog_o only when RISTRETTO_PCU_WATCHDOG_EN is defined (sticky stall watchdog).
module ristretto_pipe_ctrl_unit #(
    parameter int DataWidth   = 32,
    parameter int FlushCycles = 2,
    parameter int WdogLimit   = 1024
) (
    input  logic                        clk_i,
    input  logic                        rstn_i,
    ristretto_pipe_ctrl_unit_if.slave   pcu
`ifdef RISTRETTO_PCU_WATCHDOG_EN
    ,
    output logic                        pcu_wdog_o
`endif
);
    typedef enum logic [1:0] {
        ST_RUN      = 2'd0,
        ST_FLUSH    = 2'd1,
        ST_MEM_WAIT = 2'd2
    } state_e;

    localparam logic [1:0] CntLoad = 2'(FlushCycles - 1);

    state_e     state_q, state_d;
    logic [1:0] cnt_q, cnt_d;
    logic       accept;

    // Redirects and traps only take effect when memory is not holding the pipe.
    assign accept = !pcu.pcu_mem_busy_i && (pcu.pcu_trap_i || pcu.pcu_redirect_i);

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state_q <= ST_RUN;
            cnt_q   <= 2'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (pcu.pcu_mem_busy_i) begin
            state_d = ST_MEM_WAIT;
            cnt_d   = 2'd0;
        end else if (accept) begin
            // The accepting cycle is the first flush cycle; the counter holds the remaining ones.
            cnt_d   = CntLoad;
            state_d = (FlushCycles > 1) ? ST_FLUSH : ST_RUN;
        end else if (state_q == ST_FLUSH) begin
            // Leave when the decremented count reaches zero: this is the last flush cycle.
            if (cnt_q <= 2'd1) begin
                cnt_d   = 2'd0;
                state_d = ST_RUN;
            end else begin
                cnt_d = cnt_q - 2'd1;
            end
        end else begin
            state_d = ST_RUN;
        end
    end

    always_comb begin
        pcu.pcu_if_stall_o     = 1'b0;
        pcu.pcu_if_dec_stall_o = 1'b0;
        pcu.pcu_if_dec_flush_o = 1'b0;
        pcu.pcu_dec_ex_stall_o = 1'b0;
        pcu.pcu_dec_ex_flush_o = 1'b0;
        pcu.pcu_ex_mem_stall_o = 1'b0;
        pcu.pcu_ex_mem_flush_o = 1'b0;
        pcu.pcu_pc_load_o      = 1'b0;
        pcu.pcu_pc_o           = '0;
        pcu.pcu_state_o        = state_q;
        if (pcu.pcu_mem_busy_i) begin
            pcu.pcu_if_stall_o     = 1'b1;
            pcu.pcu_if_dec_stall_o = 1'b1;
            pcu.pcu_dec_ex_stall_o = 1'b1;
            pcu.pcu_ex_mem_stall_o = 1'b1;
        end else if (pcu.pcu_trap_i) begin
            pcu.pcu_pc_load_o      = 1'b1;
            pcu.pcu_pc_o           = pcu.pcu_trap_vec_i;
            pcu.pcu_if_dec_flush_o = 1'b1;
            pcu.pcu_dec_ex_flush_o = 1'b1;
            pcu.pcu_ex_mem_flush_o = 1'b1;
        end else if (pcu.pcu_redirect_i) begin
            // The redirecting instruction itself sits in EX and must still retire.
            pcu.pcu_pc_load_o      = 1'b1;
            pcu.pcu_pc_o           = pcu.pcu_redirect_pc_i;
            pcu.pcu_if_dec_flush_o = 1'b1;
            pcu.pcu_dec_ex_flush_o = 1'b1;
        end else if (state_q == ST_FLUSH) begin
            // Only bubbles reach DEC here, so md_busy/load_use are irrelevant.
            pcu.pcu_if_dec_flush_o = 1'b1;
        end else if (pcu.pcu_md_busy_i) begin
            pcu.pcu_if_stall_o     = 1'b1;
            pcu.pcu_if_dec_stall_o = 1'b1;
            pcu.pcu_dec_ex_stall_o = 1'b1;
        end else if (pcu.pcu_load_use_i) begin
            pcu.pcu_if_stall_o     = 1'b1;
            pcu.pcu_if_dec_stall_o = 1'b1;
            pcu.pcu_dec_ex_flush_o = 1'b1;
        end
    end

`ifdef RISTRETTO_PCU_WATCHDOG_EN
    logic [15:0] wdog_cnt_q, wdog_cnt_d;
    logic        wdog_q, wdog_d;

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            wdog_cnt_q <= 16'd0;
            wdog_q     <= 1'b0;
        end else begin
            wdog_cnt_q <= wdog_cnt_d;
            wdog_q     <= wdog_d;
        end
    end

    always_comb begin
        wdog_cnt_d = 16'd0;
        if (pcu.pcu_if_stall_o) begin
            wdog_cnt_d = (wdog_cnt_q == 16'hFFFF) ? wdog_cnt_q : wdog_cnt_q + 16'd1;
        end
        wdog_d = wdog_q || (wdog_cnt_d >= 16'(WdogLimit));
    end

    assign pcu_wdog_o = wdog_q;
`endif
endmodule

// File: tb/tb_ristretto_pipe_ctrl_unit.sv
module tb_ristretto_pipe_ctrl_unit;
    localparam int FC = 2;
    localparam int WL = 8;

    logic clk_i = 1'b0;
    logic rstn_i;
    int   errors = 0;
    int   checks = 0;

    ristretto_pipe_ctrl_unit_if #(.DataWidth(32)) bus ();

`ifdef RISTRETTO_PCU_WATCHDOG_EN
    logic wdog;
    ristretto_pipe_ctrl_unit #(.DataWidth(32), .FlushCycles(FC), .WdogLimit(WL)) dut (
        .clk_i(clk_i), .rstn_i(rstn_i), .pcu(bus), .pcu_wdog_o(wdog));
`else
    ristretto_pipe_ctrl_unit #(.DataWidth(32), .FlushCycles(FC), .WdogLimit(WL)) dut (
        .clk_i(clk_i), .rstn_i(rstn_i), .pcu(bus));
`endif

    always #5 clk_i = ~clk_i;

    // Reference model: remaining flush cycles after the current one, memory-wait flag,
    // consecutive fetch-stall run length and sticky watchdog.
    int flush_left;
    bit mem_wait;
    int stall_run;
    bit exp_wdog;

    function automatic logic [7:0] obs_ctl();
        return {bus.pcu_if_stall_o, bus.pcu_if_dec_stall_o, bus.pcu_if_dec_flush_o,
                bus.pcu_dec_ex_stall_o, bus.pcu_dec_ex_flush_o,
                bus.pcu_ex_mem_stall_o, bus.pcu_ex_mem_flush_o, bus.pcu_pc_load_o};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        flush_left = 0;
        mem_wait   = 0;
        stall_run  = 0;
        exp_wdog   = 0;
    endtask

    task automatic drive(input bit lu, md, mb, rd, input logic [31:0] rpc,
                         input bit tr, input logic [31:0] tvec);
        bus.pcu_load_use_i    = lu;
        bus.pcu_md_busy_i     = md;
        bus.pcu_mem_busy_i    = mb;
        bus.pcu_redirect_i    = rd;
        bus.pcu_redirect_pc_i = rpc;
        bus.pcu_trap_i        = tr;
        bus.pcu_trap_vec_i    = tvec;
    endtask

    // One clock cycle: drive after the edge, check mid-cycle against the model, advance the model.
    task automatic cyc(input string tag, input bit lu, md, mb, rd, input logic [31:0] rpc,
                       input bit tr, input logic [31:0] tvec);
        bit ifs, ids, idf, des, def, ems, emf, pl;
        logic [31:0] epc;
        logic [1:0]  est;
        @(posedge clk_i);
        #1;
        drive(lu, md, mb, rd, rpc, tr, tvec);
        #3;
        {ifs, ids, idf, des, def, ems, emf, pl} = '0;
        epc = 32'd0;
        est = mem_wait ? 2'd2 : (flush_left > 0 ? 2'd1 : 2'd0);
        if (mb) begin
            ifs = 1; ids = 1; des = 1; ems = 1;
        end else if (tr) begin
            pl = 1; epc = tvec; idf = 1; def = 1; emf = 1;
        end else if (rd) begin
            pl = 1; epc = rpc; idf = 1; def = 1;
        end else if (flush_left > 0) begin
            idf = 1;
        end else if (md) begin
            ifs = 1; ids = 1; des = 1;
        end else if (lu) begin
            ifs = 1; ids = 1; def = 1;
        end
        chk({tag, ".ctl"}, {24'd0, obs_ctl()}, {24'd0, ifs, ids, idf, des, def, ems, emf, pl});
        chk({tag, ".pc"}, bus.pcu_pc_o, epc);
        chk({tag, ".state"}, {30'd0, bus.pcu_state_o}, {30'd0, est});
`ifdef RISTRETTO_PCU_WATCHDOG_EN
        chk({tag, ".wdog"}, {31'd0, wdog}, {31'd0, exp_wdog});
`endif
        if (mb) begin
            mem_wait = 1; flush_left = 0;
        end else if (tr || rd) begin
            mem_wait = 0; flush_left = FC - 1;
        end else begin
            mem_wait = 0;
            if (flush_left > 0) flush_left--;
        end
        stall_run = ifs ? stall_run + 1 : 0;
        if (stall_run >= WL) exp_wdog = 1;
    endtask

    task automatic idle(input string tag);
        cyc(tag, 0, 0, 0, 0, 32'd0, 0, 32'd0);
    endtask

    initial begin
        bit rd_p, tr_p, mb, md, lu;
        logic [31:0] rpc, tvec;
        rstn_i = 1'b0;
        drive(0, 0, 0, 0, 32'd0, 0, 32'd0);
        model_reset();
        #2;
        chk("reset.ctl", {24'd0, obs_ctl()}, 32'd0);
        chk("reset.pc", bus.pcu_pc_o, 32'd0);
        chk("reset.state", {30'd0, bus.pcu_state_o}, 32'd0);
        #10 rstn_i = 1'b1;
        idle("idle0");
        idle("idle1");

        // load-use pulse
        cyc("lu", 1, 0, 0, 0, 32'd0, 0, 32'd0);
        idle("lu_after");

        // redirect, two flush cycles then back to RUN
        cyc("rd_n0", 0, 0, 0, 1, 32'h100, 0, 32'd0);
        idle("rd_n1");
        idle("rd_n2");

        // trap beats a simultaneous redirect
        cyc("tr_rd", 0, 0, 0, 1, 32'h200, 1, 32'h80);
        idle("tr_f1");
        idle("tr_f2");

        // mem_busy for five cycles with a pending redirect, then acceptance
        for (int i = 0; i < 5; i++) cyc("mb_hold", 0, 0, 1, 1, 32'h300, 0, 32'd0);
        cyc("mb_acc", 0, 0, 0, 1, 32'h300, 0, 32'd0);
        idle("mb_f1");
        idle("mb_f2");

        // md_busy and load_use are ignored while flushing
        cyc("rd_x", 0, 0, 0, 1, 32'h440, 0, 32'd0);
        cyc("fl_md", 1, 1, 0, 0, 32'd0, 0, 32'd0);
        cyc("run_md", 1, 1, 0, 0, 32'd0, 0, 32'd0);

        // reset in the middle of a flush
        cyc("rd_rst", 0, 0, 0, 1, 32'h500, 0, 32'd0);
        @(posedge clk_i);
        #1;
        drive(0, 0, 0, 0, 32'd0, 0, 32'd0);
        #1;
        chk("pre_rst.state", {30'd0, bus.pcu_state_o}, 32'd1);
        rstn_i = 1'b0;
        #1;
        chk("mid_rst.state", {30'd0, bus.pcu_state_o}, 32'd0);
        chk("mid_rst.ctl", {24'd0, obs_ctl()}, 32'd0);
        model_reset();
        #1 rstn_i = 1'b1;
        idle("post_rst");

        // long md_busy run, exercises the optional watchdog
        for (int i = 0; i < 10; i++) cyc("md_run", 0, 1, 0, 0, 32'd0, 0, 32'd0);
        idle("md_end0");
        idle("md_end1");

        // randomized traffic; redirect/trap held until accepted
        rd_p = 0; tr_p = 0; rpc = 0; tvec = 0;
        for (int i = 0; i < 400; i++) begin
            if (!rd_p && ($urandom_range(0, 5) == 0)) begin
                rd_p = 1; rpc = $urandom & 32'hFFFF_FFFC;
            end
            if (!tr_p && ($urandom_range(0, 9) == 0)) begin
                tr_p = 1; tvec = $urandom & 32'hFFFF_FFFC;
            end
            mb = ($urandom_range(0, 3) == 0);
            md = ($urandom_range(0, 4) == 0);
            lu = ($urandom_range(0, 4) == 0);
            cyc("rand", lu, md, mb, rd_p, rpc, tr_p, tvec);
            if (!mb && (rd_p || tr_p)) begin
                rd_p = 0; tr_p = 0;
            end
        end
        idle("rand_end0");
        idle("rand_end1");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
